// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus arbiter: the owner tag
// recorded for every accepted transaction and the read byte-enable value.
package mem_bus_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [3:0] BEN_ALL = 4'b1111;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order tag FIFO of accepted memory transactions. Each entry records which
// requester owns the transaction and whether its response must be dropped.
// A broadcast set_discard marks every entry currently held, plus the entry
// being pushed in the same cycle.
module mem_arb_tag_fifo
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  owner_t                     push_owner,
    input  logic                       push_discard,
    input  logic                       pop,
    input  logic                       set_discard,
    output owner_t                     head_owner,
    output logic                       head_discard,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    owner_t           owner_q   [DEPTH];
    logic             discard_q [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic             do_push;
    logic             do_pop;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign count        = count_q;
    assign head_owner   = owner_q[rd_ptr];
    assign head_discard = discard_q[rd_ptr];
    assign do_push      = push & ~full;
    assign do_pop       = pop & ~empty;

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count_q);
        end
    end

    // Pointer, count and tag storage updates; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                owner_q[i]   <= OWN_INST;
                discard_q[i] <= 1'b0;
            end
        end else begin
            if (set_discard) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entry_valid[i]) begin
                        discard_q[i] <= 1'b1;
                    end
                end
            end
            if (do_push) begin
                owner_q[wr_ptr]   <= push_owner;
                discard_q[wr_ptr] <= push_discard | set_discard;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the MEM-stage
// data port. Data requests win over fetches; a tag FIFO remembers who owns each
// accepted transaction so in-order responses can be routed back, and responses
// of transactions squashed by a pipeline cancel are silently dropped.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cancel,
    input  logic                       i_req,
    input  logic [ADDR_W-1:0]          i_addr,
    output logic                       i_addr_ok,
    output logic                       i_data_ok,
    output logic [31:0]                i_rdata,
    input  logic                       d_req,
    input  logic                       d_wr,
    input  logic [3:0]                 d_ben,
    input  logic [ADDR_W-1:0]          d_addr,
    input  logic [31:0]                d_wdata,
    output logic                       d_addr_ok,
    output logic                       d_data_ok,
    output logic [31:0]                d_rdata,
    output logic                       m_req,
    output logic                       m_wr,
    output logic [3:0]                 m_ben,
    output logic [ADDR_W-1:0]          m_addr,
    output logic [31:0]                m_wdata,
    input  logic                       m_addr_ok,
    input  logic                       m_data_ok,
    input  logic [31:0]                m_rdata,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       proto_err
);

    logic   sel_d;
    logic   sel_i;
    logic   acc;
    logic   pop;
    logic   deliver;
    logic   fifo_empty;
    logic   fifo_full;
    logic   head_discard;
    owner_t head_owner;
    owner_t push_owner;

    mem_arb_tag_fifo #(
        .DEPTH(DEPTH)
    ) u_tag_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (acc),
        .push_owner   (push_owner),
        .push_discard (cancel),
        .pop          (pop),
        .set_discard  (cancel),
        .head_owner   (head_owner),
        .head_discard (head_discard),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .count        (outstanding)
    );

    // Request side: fixed data-over-fetch grant and the address-phase mux.
    always_comb begin
        sel_d      = d_req;
        sel_i      = i_req & ~d_req;
        m_req      = (d_req | i_req) & ~fifo_full;
        m_wr       = 1'b0;
        m_ben      = BEN_ALL;
        m_addr     = i_addr;
        m_wdata    = '0;
        push_owner = OWN_INST;
        if (sel_d) begin
            m_wr       = d_wr;
            m_ben      = d_ben;
            m_addr     = d_addr;
            m_wdata    = d_wdata;
            push_owner = OWN_DATA;
        end
        acc       = m_req & m_addr_ok;
        d_addr_ok = acc & sel_d;
        i_addr_ok = acc & sel_i;
    end

    // Response side: pop the head and route the data to its owner unless squashed.
    always_comb begin
        pop       = m_data_ok & ~fifo_empty;
        deliver   = pop & ~head_discard;
        i_data_ok = 1'b0;
        d_data_ok = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        if (deliver) begin
            if (head_owner == OWN_DATA) begin
                d_data_ok = 1'b1;
                d_rdata   = m_rdata;
            end else begin
                i_data_ok = 1'b1;
                i_rdata   = m_rdata;
            end
        end
    end

    // Sticky flag for a memory response that arrives with nothing outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (m_data_ok && fifo_empty) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with DEPTH=2. Inputs change 1ns after
// the rising edge; combinational outputs are checked 1ns later, well before the
// next edge.
module tb_mem_bus_arbiter;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 32;

    logic        clk;
    logic        reset;
    logic        cancel;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [3:0]  d_ben;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_wr;
    logic [3:0]  m_ben;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;
    logic [1:0]  outstanding;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cancel      (cancel),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_addr_ok   (i_addr_ok),
        .i_data_ok   (i_data_ok),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_wr        (d_wr),
        .d_ben       (d_ben),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_addr_ok   (d_addr_ok),
        .d_data_ok   (d_data_ok),
        .d_rdata     (d_rdata),
        .m_req       (m_req),
        .m_wr        (m_wr),
        .m_ben       (m_ben),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_addr_ok   (m_addr_ok),
        .m_data_ok   (m_data_ok),
        .m_rdata     (m_rdata),
        .outstanding (outstanding),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        cancel    = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_wr      = 1'b0;
        d_ben     = 4'b0000;
        d_addr    = '0;
        d_wdata   = '0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
        checks++; if ({m_req, m_wr, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 6'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 000000", {m_req, m_wr, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}); end
        checks++; if ({i_rdata, d_rdata, m_wdata} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {i_rdata, d_rdata, m_wdata}); end
    endtask

    task automatic test_priority();
        next_cycle();
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_wr = 1'b0; d_ben = 4'b1111; d_addr = 32'h100;
        m_addr_ok = 1'b1;
        #1;
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h100) begin errors++; $display("FAIL prio_maddr: got req=%b addr=%h expected req=1 addr=00000100", m_req, m_addr); end
        checks++; if ({d_addr_ok, i_addr_ok, m_wr} !== 3'b100) begin errors++; $display("FAIL prio_addr_ok: got d/i/wr=%b expected 100", {d_addr_ok, i_addr_ok, m_wr}); end
        next_cycle();
        idle_inputs();
        m_data_ok = 1'b1; m_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL prio_outstanding: got %0d expected 1", outstanding); end
        checks++; if (d_data_ok !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL prio_drsp: got ok=%b data=%h expected ok=1 data=deadbeef", d_data_ok, d_rdata); end
        checks++; if (i_data_ok !== 1'b0 || i_rdata !== 32'h0) begin errors++; $display("FAIL prio_irsp: got ok=%b data=%h expected ok=0 data=0", i_data_ok, i_rdata); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL prio_drain: got %0d expected 0", outstanding); end
    endtask

    task automatic test_fill();
        i_req = 1'b1; i_addr = 32'h200; m_addr_ok = 1'b1;
        #1;
        checks++; if (i_addr_ok !== 1'b1 || m_addr !== 32'h200 || m_ben !== 4'b1111) begin errors++; $display("FAIL fill_inst: got ok=%b addr=%h ben=%b expected ok=1 addr=00000200 ben=1111", i_addr_ok, m_addr, m_ben); end
        next_cycle();
        checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL fill_cnt1: got %0d expected 1", outstanding); end
        i_req = 1'b0; d_req = 1'b1; d_wr = 1'b0; d_ben = 4'b1111; d_addr = 32'h300;
        #1;
        checks++; if (d_addr_ok !== 1'b1) begin errors++; $display("FAIL fill_data_acc: got %b expected 1", d_addr_ok); end
        next_cycle();
        checks++; if (outstanding !== 2'd2) begin errors++; $display("FAIL fill_cnt2: got %0d expected 2", outstanding); end
        i_req = 1'b1;
        m_data_ok = 1'b1; m_rdata = 32'h11;
        #1;
        checks++; if (m_req !== 1'b0 || d_addr_ok !== 1'b0 || i_addr_ok !== 1'b0) begin errors++; $display("FAIL fill_full_block: got req=%b dok=%b iok=%b expected 0 0 0", m_req, d_addr_ok, i_addr_ok); end
        checks++; if (i_data_ok !== 1'b1 || i_rdata !== 32'h11 || d_data_ok !== 1'b0) begin errors++; $display("FAIL fill_rsp1: got iok=%b idata=%h dok=%b expected 1 00000011 0", i_data_ok, i_rdata, d_data_ok); end
        next_cycle();
        checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL fill_cnt3: got %0d expected 1", outstanding); end
        i_req = 1'b0; m_addr_ok = 1'b0; m_rdata = 32'h22;
        #1;
        checks++; if (m_req !== 1'b1 || d_addr_ok !== 1'b0) begin errors++; $display("FAIL fill_reopen: got req=%b dok=%b expected req=1 dok=0", m_req, d_addr_ok); end
        checks++; if (d_data_ok !== 1'b1 || d_rdata !== 32'h22 || i_data_ok !== 1'b0) begin errors++; $display("FAIL fill_rsp2: got dok=%b ddata=%h iok=%b expected 1 00000022 0", d_data_ok, d_rdata, i_data_ok); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL fill_cnt4: got %0d expected 0", outstanding); end
    endtask

    task automatic test_cancel();
        i_req = 1'b1; i_addr = 32'h600; m_addr_ok = 1'b1;
        next_cycle();
        i_addr = 32'h604;
        next_cycle();
        idle_inputs();
        checks++; if (outstanding !== 2'd2) begin errors++; $display("FAIL cancel_cnt: got %0d expected 2", outstanding); end
        cancel = 1'b1;
        next_cycle();
        cancel = 1'b0;
        m_data_ok = 1'b1; m_rdata = 32'hAAAA;
        #1;
        checks++; if (i_data_ok !== 1'b0 || i_rdata !== 32'h0) begin errors++; $display("FAIL cancel_drop1: got ok=%b data=%h expected ok=0 data=0", i_data_ok, i_rdata); end
        next_cycle();
        m_rdata = 32'hBBBB;
        #1;
        checks++; if (i_data_ok !== 1'b0 || d_data_ok !== 1'b0) begin errors++; $display("FAIL cancel_drop2: got iok=%b dok=%b expected 0 0", i_data_ok, d_data_ok); end
        next_cycle();
        idle_inputs();
        checks++; if (outstanding !== 2'd0 || proto_err !== 1'b0) begin errors++; $display("FAIL cancel_drain: got cnt=%0d perr=%b expected 0 0", outstanding, proto_err); end
        i_req = 1'b1; i_addr = 32'h608; m_addr_ok = 1'b1;
        next_cycle();
        idle_inputs();
        m_data_ok = 1'b1; m_rdata = 32'h1234;
        #1;
        checks++; if (i_data_ok !== 1'b1 || i_rdata !== 32'h1234) begin errors++; $display("FAIL cancel_after: got ok=%b data=%h expected ok=1 data=00001234", i_data_ok, i_rdata); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_wr = 1'b1; d_ben = 4'b0011; d_addr = 32'h400; d_wdata = 32'h0000ABCD;
        i_req = 1'b1; i_addr = 32'h700; m_addr_ok = 1'b1;
        #1;
        checks++; if (m_wr !== 1'b1 || m_ben !== 4'b0011) begin errors++; $display("FAIL store_ctrl: got wr=%b ben=%b expected wr=1 ben=0011", m_wr, m_ben); end
        checks++; if (m_addr !== 32'h400 || m_wdata !== 32'h0000ABCD || d_addr_ok !== 1'b1) begin errors++; $display("FAIL store_bus: got addr=%h wdata=%h ok=%b expected 00000400 0000abcd 1", m_addr, m_wdata, d_addr_ok); end
        next_cycle();
        idle_inputs();
        m_data_ok = 1'b1;
        #1;
        checks++; if (d_data_ok !== 1'b1 || i_data_ok !== 1'b0) begin errors++; $display("FAIL store_done: got dok=%b iok=%b expected 1 0", d_data_ok, i_data_ok); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        i_req = 1'b1; i_addr = 32'h800; m_addr_ok = 1'b1;
        next_cycle();
        idle_inputs();
        d_req = 1'b1; d_wr = 1'b0; d_ben = 4'b1111; d_addr = 32'h500; m_addr_ok = 1'b1;
        m_data_ok = 1'b1; m_rdata = 32'h55;
        #1;
        checks++; if (i_data_ok !== 1'b1 || i_rdata !== 32'h55 || d_data_ok !== 1'b0) begin errors++; $display("FAIL b2b_old_head: got iok=%b idata=%h dok=%b expected 1 00000055 0", i_data_ok, i_rdata, d_data_ok); end
        checks++; if (d_addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", d_addr_ok); end
        next_cycle();
        idle_inputs();
        checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL b2b_cnt: got %0d expected 1", outstanding); end
        m_data_ok = 1'b1; m_rdata = 32'h66;
        #1;
        checks++; if (d_data_ok !== 1'b1 || d_rdata !== 32'h66) begin errors++; $display("FAIL b2b_new_head: got ok=%b data=%h expected ok=1 data=00000066", d_data_ok, d_rdata); end
        next_cycle();
        idle_inputs();
        checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", outstanding); end
    endtask

    task automatic test_proto_err();
        m_data_ok = 1'b1; m_rdata = 32'h77;
        #1;
        checks++; if (i_data_ok !== 1'b0 || d_data_ok !== 1'b0) begin errors++; $display("FAIL perr_no_rsp: got iok=%b dok=%b expected 0 0", i_data_ok, d_data_ok); end
        next_cycle();
        idle_inputs();
        checks++; if (proto_err !== 1'b1 || outstanding !== 2'd0) begin errors++; $display("FAIL perr_set: got perr=%b cnt=%0d expected 1 0", proto_err, outstanding); end
        next_cycle();
        next_cycle();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b expected 1", proto_err); end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b expected 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_fill();
        test_cancel();
        test_store();
        test_back_to_back();
        test_proto_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
